// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches floor calls, serves them with a SCAN
// (keep-direction) policy, and times per-floor travel and door opening.
module elevator_ctrl_n #(
  parameter int N_FLOORS      = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  localparam int FW           = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req,
  output logic [N_FLOORS-1:0] pending,
  output logic [FW-1:0]       floor,
  output logic                up,
  output logic                down,
  output logic                open,
  output logic                dir_up
);
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t              state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;

  logic [N_FLOORS-1:0] served, door_mask;
  logic [FW-1:0]       nf;
  logic [DW-1:0]       deff;

  function automatic logic any_above(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (i > int'(f)) any_above = any_above | p[i];
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (i < int'(f)) any_below = any_below | p[i];
  endfunction

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    tcnt_d    = tcnt_q;
    dcnt_d    = dcnt_q;
    served    = '0;
    door_mask = '0;
    nf        = floor_q;
    deff      = dcnt_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        if (pending_q[floor_q]) begin
          state_d         = DOOR_OPEN;
          served[floor_q] = 1'b1;
        end else if (dir_q && any_above(pending_q, floor_q)) begin
          state_d = MOVE_UP;
        end else if (any_below(pending_q, floor_q)) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end else if (any_above(pending_q, floor_q)) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (tcnt_q == TW'(TRAVEL_CYCLES - 1)) begin
          tcnt_d = '0;
          // Guards keep floor in range even if the target were lost.
          if (state_q == MOVE_UP && int'(floor_q) < N_FLOORS - 1) nf = floor_q + 1'b1;
          if (state_q == MOVE_DOWN && floor_q != '0)              nf = floor_q - 1'b1;
          floor_d = nf;
          if (pending_q[nf]) begin
            state_d    = DOOR_OPEN;
            served[nf] = 1'b1;
          end else if (state_q == MOVE_UP ? !any_above(pending_q, nf)
                                          : !any_below(pending_q, nf)) begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DOOR_OPEN: begin
        // A call for this floor while open restarts the window; the reload
        // cycle itself counts as the first cycle of the new window.
        door_mask[floor_q] = 1'b1;
        if (req[floor_q]) deff = '0;
        if (deff == DW'(DOOR_CYCLES - 1)) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = deff + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | (req & ~door_mask)) & ~served;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign pending = pending_q;
  assign floor   = floor_q;
  assign dir_up  = dir_q;
  assign up      = (state_q == MOVE_UP);
  assign down    = (state_q == MOVE_DOWN);
  assign open    = (state_q == DOOR_OPEN);
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Scoreboard bench for elevator_ctrl_n: directed calls push hand-computed
// per-cycle output snapshots; a negedge monitor pops and compares them.
module tb_elevator_ctrl_n;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] pending;
  logic [2:0] floor;
  logic       up, down, open, dir_up;

  elevator_ctrl_n #(.N_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req(req), .pending(pending), .floor(floor),
    .up(up), .down(down), .open(open), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [14:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  wire [14:0] got = {pending, floor, up, down, open, dir_up};

  function automatic logic [14:0] E(input logic [7:0] p, input logic [2:0] f,
                                    input logic u, input logic d, input logic o, input logic dr);
    return {p, f, u, d, o, dr};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got pend=%h floor=%0d up/dn/open/dir=%b, want pend=%h floor=%0d up/dn/open/dir=%b",
                 e.nm, got[14:7], got[6:4], got[3:0], e.v[14:7], e.v[6:4], e.v[3:0]);
      end
    end
  end

  // Drive r/rs into the next edge, then expect ev for the cycle after it.
  task automatic cyc(input logic [7:0] r, input logic rs, input string nm, input logic [14:0] ev);
    req = r;
    rst = rs;
    @(posedge clk);
    #1;
    q.push_back('{nm: nm, v: ev});
  endtask

  initial begin
    // Reset
    cyc(8'h00, 1'b1, "reset1", E(8'h00, 3'd0, 0, 0, 0, 1));
    cyc(8'h00, 1'b1, "reset2", E(8'h00, 3'd0, 0, 0, 0, 1));
    cyc(8'h00, 1'b0, "idle0",  E(8'h00, 3'd0, 0, 0, 0, 1));

    // Same-floor call
    cyc(8'h01, 1'b0, "same_latch", E(8'h01, 3'd0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, "same_open", E(8'h00, 3'd0, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "same_idle", E(8'h00, 3'd0, 0, 0, 0, 1));

    // Travel 0 -> 3
    cyc(8'h08, 1'b0, "trav_latch", E(8'h08, 3'd0, 0, 0, 0, 1));
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) cyc(8'h00, 1'b0, "trav_up", E(8'h08, 3'(f), 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, "trav_open", E(8'h00, 3'd3, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "trav_idle", E(8'h00, 3'd3, 0, 0, 0, 1));

    // SCAN: at 3 heading up, calls at 5 and 1 -> 5 first, then down to 1
    cyc(8'h22, 1'b0, "scan_latch", E(8'h22, 3'd3, 0, 0, 0, 1));
    for (int f = 3; f < 5; f++)
      for (int c = 0; c < 4; c++) cyc(8'h00, 1'b0, "scan_up", E(8'h22, 3'(f), 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, "scan_open5", E(8'h02, 3'd5, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "scan_idle5", E(8'h02, 3'd5, 0, 0, 0, 1));
    for (int f = 5; f > 1; f--)
      for (int c = 0; c < 4; c++) cyc(8'h00, 1'b0, "scan_down", E(8'h02, 3'(f), 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, "scan_open1", E(8'h00, 3'd1, 0, 0, 1, 0));
    cyc(8'h00, 1'b0, "scan_idle1", E(8'h00, 3'd1, 0, 0, 0, 0));

    // Door reload at floor 2: req[2] during 2nd open cycle -> 4 open cycles
    cyc(8'h04, 1'b0, "rl_latch", E(8'h04, 3'd1, 0, 0, 0, 0));
    for (int c = 0; c < 4; c++) cyc(8'h00, 1'b0, "rl_up", E(8'h04, 3'd1, 1, 0, 0, 1));
    cyc(8'h00, 1'b0, "rl_open1", E(8'h00, 3'd2, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "rl_open2", E(8'h00, 3'd2, 0, 0, 1, 1));
    cyc(8'h04, 1'b0, "rl_open3", E(8'h00, 3'd2, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "rl_open4", E(8'h00, 3'd2, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "rl_idle",  E(8'h00, 3'd2, 0, 0, 0, 1));

    // Clear wins over a simultaneous call for the floor being served
    cyc(8'h04, 1'b0, "cw_latch", E(8'h04, 3'd2, 0, 0, 0, 1));
    cyc(8'h04, 1'b0, "cw_clear", E(8'h00, 3'd2, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "cw_open2", E(8'h00, 3'd2, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "cw_open3", E(8'h00, 3'd2, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "cw_idle",  E(8'h00, 3'd2, 0, 0, 0, 1));

    // Reset mid-move between floors 4 and 5
    cyc(8'h80, 1'b0, "rm_latch", E(8'h80, 3'd2, 0, 0, 0, 1));
    for (int f = 2; f < 4; f++)
      for (int c = 0; c < 4; c++) cyc(8'h00, 1'b0, "rm_up", E(8'h80, 3'(f), 1, 0, 0, 1));
    cyc(8'h00, 1'b0, "rm_up4", E(8'h80, 3'd4, 1, 0, 0, 1));
    cyc(8'h00, 1'b0, "rm_up4", E(8'h80, 3'd4, 1, 0, 0, 1));
    cyc(8'h00, 1'b1, "rm_reset", E(8'h00, 3'd0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, "rm_still", E(8'h00, 3'd0, 0, 0, 0, 1));

    // Full range: 0 -> 7 (top boundary), then 7 -> 0 (bottom boundary)
    cyc(8'h80, 1'b0, "top_latch", E(8'h80, 3'd0, 0, 0, 0, 1));
    for (int f = 0; f < 7; f++)
      for (int c = 0; c < 4; c++) cyc(8'h00, 1'b0, "top_up", E(8'h80, 3'(f), 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, "top_open", E(8'h00, 3'd7, 0, 0, 1, 1));
    cyc(8'h00, 1'b0, "top_idle", E(8'h00, 3'd7, 0, 0, 0, 1));
    cyc(8'h01, 1'b0, "bot_latch", E(8'h01, 3'd7, 0, 0, 0, 1));
    for (int f = 7; f > 0; f--)
      for (int c = 0; c < 4; c++) cyc(8'h00, 1'b0, "bot_down", E(8'h01, 3'(f), 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, "bot_open", E(8'h00, 3'd0, 0, 0, 1, 0));
    cyc(8'h00, 1'b0, "bot_idle", E(8'h00, 3'd0, 0, 0, 0, 0));

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
